// File: rtl/stln_pkg.sv
// rtl/stln_pkg.sv - shared widths and FSM states for the straight-line generator/fitter pair
package stln_pkg;

    localparam int STLN_W_Y = 32;
    localparam int STLN_W_P = 8;

    typedef enum logic [1:0] {
        S_WAIT1 = 2'd0,
        S_WAIT2 = 2'd1,
        S_TRACK = 2'd2,
        S_ERR   = 2'd3
    } stln_state_e;

endpackage

// File: rtl/stln_fit_derive.sv
// rtl/stln_fit_derive.sv - combinational slope/intercept recovery from the first two samples
module stln_fit_derive #(
    parameter int W_Y = 32,
    parameter int W_P = 8
) (
    input  logic [W_Y-1:0] y,
    input  logic [W_Y-1:0] y1,
    output logic [W_P-1:0] d,
    output logic [W_P-1:0] cc,
    output logic           fit_ok
);

    logic [W_Y-1:0] d_full;
    logic [W_Y-1:0] cc_full;

    // slope is the first difference, intercept steps back one x from y1
    always_comb begin
        d_full  = y - y1;
        cc_full = y1 - d_full;
    end

    // only the low W_P bits are meaningful once the range check passes
    assign d      = d_full[W_P-1:0];
    assign cc     = cc_full[W_P-1:0];
    assign fit_ok = (d_full[W_Y-1:W_P] == '0) && (cc_full[W_Y-1:W_P] == '0);

endmodule

// File: rtl/stln_fit.sv
// rtl/stln_fit.sv - line parameter recovery and tracking; STLN_FIT_RESYNC_EN turns faults into resync pulses
module stln_fit
    import stln_pkg::*;
#(
    parameter int W_Y         = STLN_W_Y,
    parameter int W_P         = STLN_W_P,
    parameter int LOCK_CHECKS = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ce,
    input  logic [W_Y-1:0] y,
    output logic [W_P-1:0] m,
    output logic [W_P-1:0] c,
    output logic           params_valid,
    output logic           locked,
    output logic           err,
    output logic [W_Y-1:0] y_pred,
    output logic [15:0]    n_samples
);

    localparam logic [3:0] CHK_MAX = 4'(LOCK_CHECKS);

    stln_state_e    state;
    logic [W_Y-1:0] y1_r;
    logic [W_Y-1:0] y_pred_r;
    logic [W_P-1:0] m_r;
    logic [W_P-1:0] c_r;
    logic           pv_r;
    logic           lk_r;
    logic           err_r;
    logic [15:0]    n_r;
    logic [3:0]     chk_r;

    logic [W_P-1:0] d;
    logic [W_P-1:0] cc;
    logic           fit_ok;
    logic [W_Y-1:0] m_ext;
    logic [W_Y-1:0] d_ext;

    stln_fit_derive #(
        .W_Y (W_Y),
        .W_P (W_P)
    ) u_derive (
        .y      (y),
        .y1     (y1_r),
        .d      (d),
        .cc     (cc),
        .fit_ok (fit_ok)
    );

    assign m_ext = {{(W_Y-W_P){1'b0}}, m_r};
    assign d_ext = {{(W_Y-W_P){1'b0}}, d};

    // accepted-sample counter runs in every state and saturates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_r <= 16'd0;
        end else if (ce && (n_r != 16'hFFFF)) begin
            n_r <= n_r + 16'd1;
        end
    end

    // derive m/c from the first two samples, then track the prediction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_WAIT1;
            y1_r     <= '0;
            y_pred_r <= '0;
            m_r      <= '0;
            c_r      <= '0;
            pv_r     <= 1'b0;
            lk_r     <= 1'b0;
            err_r    <= 1'b0;
            chk_r    <= 4'd0;
        end else if (ce) begin
`ifdef STLN_FIT_RESYNC_EN
            err_r <= 1'b0;
`endif
            case (state)
                S_WAIT1: begin
                    y1_r  <= y;
                    state <= S_WAIT2;
                end
                S_WAIT2: begin
                    if (!fit_ok) begin
                        err_r <= 1'b1;
`ifdef STLN_FIT_RESYNC_EN
                        state <= S_WAIT1;
`else
                        state <= S_ERR;
`endif
                    end else begin
                        m_r      <= d;
                        c_r      <= cc;
                        pv_r     <= 1'b1;
                        y_pred_r <= y + d_ext;
                        chk_r    <= 4'd0;
                        state    <= S_TRACK;
                    end
                end
                S_TRACK: begin
                    if (y == y_pred_r) begin
                        y_pred_r <= y_pred_r + m_ext;
                        if (chk_r < CHK_MAX) chk_r <= chk_r + 4'd1;
                        if (chk_r >= CHK_MAX - 4'd1) lk_r <= 1'b1;
                    end else begin
                        err_r <= 1'b1;
                        lk_r  <= 1'b0;
`ifdef STLN_FIT_RESYNC_EN
                        // the offending sample becomes x=1 of a fresh fit
                        pv_r  <= 1'b0;
                        chk_r <= 4'd0;
                        y1_r  <= y;
                        state <= S_WAIT2;
`else
                        state <= S_ERR;
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign m            = m_r;
    assign c            = c_r;
    assign params_valid = pv_r;
    assign locked       = lk_r;
    assign err          = err_r;
    assign y_pred       = y_pred_r;
    assign n_samples    = n_r;

endmodule

// File: tb/tb_stln_fit.sv
// tb/tb_stln_fit.sv - vector table, directed corner sequences and random streams against a closed-form model
module tb_stln_fit;

    localparam int LC = 2;

    typedef struct {
        logic [7:0]  m;
        logic [7:0]  c;
        logic        pv;
        logic        lk;
        logic        er;
        logic [31:0] yp;
        logic [15:0] n;
    } outs_t;

    typedef struct {
        bit          rst;
        logic [31:0] y;
        outs_t       e;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        ce;
    logic [31:0] y;
    logic [7:0]  m, c;
    logic        params_valid, locked, err;
    logic [31:0] y_pred;
    logic [15:0] n_samples;

    logic [15:0] yw;
    logic [7:0]  wm, wc;
    logic        wpv, wlk, werr;
    logic [15:0] wyp;
    logic [15:0] wn;

    int vec_cnt = 0;
    int err_cnt = 0;

    vec_t        tbl[$];
    logic [31:0] q[$];

    stln_fit #(.W_Y(32), .W_P(8), .LOCK_CHECKS(LC)) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .y(y),
        .m(m), .c(c), .params_valid(params_valid), .locked(locked),
        .err(err), .y_pred(y_pred), .n_samples(n_samples)
    );

    stln_fit #(.W_Y(16), .W_P(8), .LOCK_CHECKS(LC)) dut_w (
        .clk(clk), .rst_n(rst_n), .ce(ce), .y(yw),
        .m(wm), .c(wc), .params_valid(wpv), .locked(wlk),
        .err(werr), .y_pred(wyp), .n_samples(wn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not reach summary");
        $fatal(1, "timeout");
    end

    function automatic outs_t mk(input logic [7:0] m_v, input logic [7:0] c_v, input logic pv_v,
                                 input logic lk_v, input logic er_v, input logic [31:0] yp_v,
                                 input logic [15:0] n_v);
        outs_t o;
        o.m = m_v; o.c = c_v; o.pv = pv_v; o.lk = lk_v; o.er = er_v; o.yp = yp_v; o.n = n_v;
        return o;
    endfunction

    task automatic add(input bit r, input logic [31:0] yv, input logic [7:0] mv, input logic [7:0] cv,
                       input logic pv, input logic lk, input logic er, input logic [31:0] yp,
                       input logic [15:0] n);
        vec_t v;
        v.rst = r; v.y = yv; v.e = mk(mv, cv, pv, lk, er, yp, n);
        tbl.push_back(v);
    endtask

    // closed-form expectation: y_k = c + m*k for every sample from x=1
    function automatic outs_t model();
        outs_t       e;
        logic [31:0] d, cc, pred;
        int          len;
        bit          bad;
        e = mk(8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 32'd0, 16'd0);
        len = q.size();
        e.n = (len > 65535) ? 16'hFFFF : 16'(len);
        if (len >= 2) begin
            d  = q[1] - q[0];
            cc = q[0] - d;
            if (d > 32'd255 || cc > 32'd255) begin
                e.er = 1'b1;
            end else begin
                e.m  = d[7:0];
                e.c  = cc[7:0];
                e.pv = 1'b1;
                bad  = 1'b0;
                for (int k = 3; k <= len; k++) begin
                    pred = cc + d * 32'(k);
                    if (!bad && q[k-1] != pred) begin
                        bad  = 1'b1;
                        e.er = 1'b1;
                        e.yp = pred;
                    end
                end
                if (!bad) begin
                    e.yp = cc + d * 32'(len + 1);
                    e.lk = ((len - 2) >= LC);
                end
            end
        end
        return e;
    endfunction

    task automatic check(input string tag, input outs_t e);
        vec_cnt++;
        if (m !== e.m || c !== e.c || params_valid !== e.pv || locked !== e.lk ||
            err !== e.er || y_pred !== e.yp || n_samples !== e.n) begin
            err_cnt++;
            $display("FAIL %s: got m=%0d c=%0d pv=%0b lk=%0b err=%0b yp=%h n=%0d, want m=%0d c=%0d pv=%0b lk=%0b err=%0b yp=%h n=%0d",
                     tag, m, c, params_valid, locked, err, y_pred, n_samples,
                     e.m, e.c, e.pv, e.lk, e.er, e.yp, e.n);
        end
    endtask

    task automatic step(input logic ce_v, input logic [31:0] y_v);
        @(negedge clk);
        ce = ce_v;
        y  = y_v;
        yw = y_v[15:0];
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        ce    = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
    endtask

    initial begin
        outs_t       e;
        logic [31:0] yy;
        logic [15:0] wexp;
        int          mr, cr, len, mode, bad_at;

        rst_n = 1'b0;
        ce    = 1'b0;
        y     = 32'd0;
        yw    = 16'd0;
        #12;
        check("reset", mk(8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 32'd0, 16'd0));
        rst_n = 1'b1;

        // m=3 c=5 clean
        add(1, 32'd8,  0, 0, 0, 0, 0, 32'd0,  1);
        add(0, 32'd11, 3, 5, 1, 0, 0, 32'd14, 2);
        add(0, 32'd14, 3, 5, 1, 0, 0, 32'd17, 3);
        add(0, 32'd17, 3, 5, 1, 1, 0, 32'd20, 4);
        // m=0 constant stream
        add(1, 32'd7, 0, 0, 0, 0, 0, 32'd0, 1);
        add(0, 32'd7, 0, 7, 1, 0, 0, 32'd7, 2);
        add(0, 32'd7, 0, 7, 1, 0, 0, 32'd7, 3);
        add(0, 32'd7, 0, 7, 1, 1, 0, 32'd7, 4);
        // mismatch on the 3rd sample
        add(1, 32'd8,  0, 0, 0, 0, 0, 32'd0,  1);
        add(0, 32'd11, 3, 5, 1, 0, 0, 32'd14, 2);
`ifdef STLN_FIT_RESYNC_EN
        add(0, 32'd15, 3, 5,  0, 0, 1, 32'd14, 3);
        add(0, 32'd18, 3, 12, 1, 0, 0, 32'd21, 4);
        add(0, 32'd21, 3, 12, 1, 0, 0, 32'd24, 5);
        add(0, 32'd24, 3, 12, 1, 1, 0, 32'd27, 6);
`else
        add(0, 32'd15, 3, 5, 1, 0, 1, 32'd14, 3);
        add(0, 32'd17, 3, 5, 1, 0, 1, 32'd14, 4);
`endif
        // slope out of range
        add(1, 32'd10,  0, 0, 0, 0, 0, 32'd0, 1);
        add(0, 32'd400, 0, 0, 0, 0, 1, 32'd0, 2);
`ifdef STLN_FIT_RESYNC_EN
        add(0, 32'd5,   0, 0, 0, 0, 0, 32'd0, 3);
`else
        add(0, 32'd5,   0, 0, 0, 0, 1, 32'd0, 3);
`endif
        // intercept out of range (negative)
        add(1, 32'd2, 0, 0, 0, 0, 0, 32'd0, 1);
        add(0, 32'd6, 0, 0, 0, 0, 1, 32'd0, 2);

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst) do_reset();
            step(1'b1, tbl[i].y);
            check($sformatf("tbl%0d", i), tbl[i].e);
        end

        // ce held low: everything holds
        do_reset();
        step(1'b1, 32'd8);
        step(1'b1, 32'd11);
        step(1'b1, 32'd14);
        step(1'b1, 32'd17);
        e = mk(3, 5, 1, 1, 0, 32'd20, 16'd4);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, $urandom);
            check($sformatf("hold%0d", i), e);
        end
        step(1'b1, 32'd20);
        check("resume", mk(3, 5, 1, 1, 0, 32'd23, 16'd5));

        // asynchronous reset between edges
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", mk(0, 0, 0, 0, 0, 32'd0, 16'd0));
        @(negedge clk);
        ce = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 32'd4);
        check("post_rst1", mk(0, 0, 0, 0, 0, 32'd0, 16'd1));
        step(1'b1, 32'd6);
        check("post_rst2", mk(2, 2, 1, 0, 0, 32'd8, 16'd2));

        // wrap through 2^16 on the narrow instance, m=200 c=50
        do_reset();
        for (int k = 1; k <= 340; k++) begin
            yy = 32'(50 + 200 * k);
            step(1'b1, yy);
            if (k >= 4) begin
                wexp = 16'(50 + 200 * (k + 1));
                vec_cnt++;
                if (wlk !== 1'b1 || werr !== 1'b0 || wyp !== wexp || wm !== 8'd200 || wc !== 8'd50) begin
                    err_cnt++;
                    $display("FAIL wrap%0d: got lk=%0b err=%0b yp=%h m=%0d c=%0d, want lk=1 err=0 yp=%h m=200 c=50",
                             k, wlk, werr, wyp, wm, wc, wexp);
                end
            end
        end

        // random streams against the closed-form model
        for (int s = 0; s < 30; s++) begin
            do_reset();
            mr  = $urandom_range(0, 255);
            cr  = $urandom_range(0, 255);
            len = $urandom_range(3, 12);
`ifdef STLN_FIT_RESYNC_EN
            mode = 0;
`else
            mode = $urandom_range(0, 2);
`endif
            bad_at = $urandom_range(3, len);
            for (int k = 1; k <= len; k++) begin
                yy = 32'(cr) + 32'(mr) * 32'(k);
                if (mode == 1 && k == bad_at) yy = yy ^ (32'd1 << $urandom_range(0, 31));
                if (mode == 2 && k <= 2) yy = 32'($urandom_range(0, 700));
                while ($urandom_range(0, 3) == 0) begin
                    step(1'b0, $urandom);
                    check($sformatf("rnd%0d_gap", s), model());
                end
                q.push_back(yy);
                step(1'b1, yy);
                check($sformatf("rnd%0d_k%0d", s, k), model());
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
